// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access via a wait-state FSM, branch PCSrc, and the MEM/WB latch.
// Optional build macro MISALIGN_TRAP_EN suppresses misaligned accesses and adds a misalign pulse.
module mem_stage #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        PCSrc,
  output logic        stall,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        ctl_q, ctl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       alu_q, alu_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              mis_q, mis_d;

  logic [31:0]       mem_q [MEM_DEPTH];
  logic [ADDR_W-1:0] idx;

  logic access, misaligned, do_access;
  logic stall_c, commit, capture, mem_we;

  assign idx    = alu_result[ADDR_W+1:2];
  assign access = memread | memwrite;

  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misaligned = access & (alu_result[1:0] != 2'b00);
`endif
    do_access = access & ~misaligned;
  end

  // Wait-state sequencing: commit marks the edge where the access completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    commit  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!do_access) begin
          capture = 1'b1;
        end else if (WAIT_STATES == 0) begin
          commit = 1'b1;
        end else begin
          stall_c = 1'b1;
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (cnt_q == CntMax) begin
          commit  = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // MEM/WB latch: full capture on idle or completion, otherwise a bubble holding data fields.
  always_comb begin
    ctl_d   = 2'b00;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    mis_d   = capture & misaligned;
    if (commit || capture) begin
      ctl_d   = misaligned ? {1'b0, wb_ctlout[0]} : wb_ctlout;
      alu_d   = alu_result;
      wreg_d  = five_bit_muxout;
      rdata_d = (commit && memread && !memwrite) ? mem_q[idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctl_q   <= 2'b00;
      rdata_q <= 32'h0;
      alu_q   <= 32'h0;
      wreg_q  <= 5'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      mis_q   <= mis_d;
    end
  end

  // Gate with rst so a store never lands while reset is held.
  assign mem_we = commit & memwrite & rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= rdata2out;
    end
  end

  assign PCSrc          = branch & zero;
  assign stall          = stall_c & rst;
  assign mem_wb_ctl     = ctl_q;
  assign read_data      = rdata_q;
  assign mem_alu_result = alu_q;
  assign mem_write_reg  = wreg_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized back-to-back traffic
// checked against a word-level memory model.
module tb_mem_stage;

  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        PCSrc, stall;
  logic [1:0]  mem_wb_ctl;
  logic [31:0] read_data, mem_alu_result;
  logic [4:0]  mem_write_reg;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mdl_mem   [DEPTH];
  bit          mdl_known [DEPTH];

  logic [1:0]  exp_ctl;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_reg;
  bit          exp_rd_known, exp_mis;
  int          exp_stall;

  always #5 clk = ~clk;

  mem_stage #(
    .MEM_DEPTH  (DEPTH),
    .ADDR_W     (AW),
    .WAIT_STATES(WS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_ctlout      (wb_ctlout),
    .branch         (branch),
    .memread        (memread),
    .memwrite       (memwrite),
    .zero           (zero),
    .alu_result     (alu_result),
    .rdata2out      (rdata2out),
    .five_bit_muxout(five_bit_muxout),
    .PCSrc          (PCSrc),
    .stall          (stall),
    .mem_wb_ctl     (mem_wb_ctl),
    .read_data      (read_data),
    .mem_alu_result (mem_alu_result),
    .mem_write_reg  (mem_write_reg)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign       (misalign)
`endif
  );

  // Reference: one access = WS stall cycles then a capture; memory is a plain word array.
  function automatic void model_access(input logic [1:0] ctl, input logic rd, input logic wr,
                                       input logic [31:0] addr, input logic [31:0] data,
                                       input logic [4:0] rg);
    bit acc;
    bit mis;
    int unsigned word;
    acc  = rd | wr;
    mis  = 0;
`ifdef MISALIGN_TRAP_EN
    mis  = acc && (addr[1:0] != 2'b00);
`endif
    word = (addr / 4) % DEPTH;
    exp_stall    = (acc && !mis) ? WS : 0;
    exp_mis      = mis;
    exp_ctl      = mis ? {1'b0, ctl[0]} : ctl;
    exp_alu      = addr;
    exp_reg      = rg;
    exp_rd       = 32'h0;
    exp_rd_known = 1;
    if (rd && !wr && !mis) begin
      exp_rd_known = mdl_known[word];
      exp_rd       = mdl_mem[word];
    end
    if (wr && !mis) begin
      mdl_mem[word]   = data;
      mdl_known[word] = 1;
    end
  endfunction

  task automatic drive(input logic [1:0] ctl, input logic br, input logic rd, input logic wr,
                       input logic zr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rg);
    wb_ctlout       = ctl;
    branch          = br;
    memread         = rd;
    memwrite        = wr;
    zero            = zr;
    alu_result      = addr;
    rdata2out       = data;
    five_bit_muxout = rg;
  endtask

  // Runs the currently driven transaction to its capture edge; reports what it observed.
  task automatic run_access(output int n_stall, output int n_badbub, output logic pc);
    logic [31:0] h_alu, h_rd;
    logic [4:0]  h_reg;
    #1;
    pc       = PCSrc;
    n_stall  = 0;
    n_badbub = 0;
    h_alu    = mem_alu_result;
    h_rd     = read_data;
    h_reg    = mem_write_reg;
    while (stall === 1'b1 && n_stall < int'(WS) + 4) begin
      @(posedge clk); #1;
      n_stall++;
      if (mem_wb_ctl !== 2'b00 || mem_alu_result !== h_alu || read_data !== h_rd ||
          mem_write_reg !== h_reg) n_badbub++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (mem_wb_ctl !== 2'b00) begin n_bad++;
      $display("FAIL reset_ctl got %b want 00", mem_wb_ctl); end
    n_vec++; if (read_data !== 32'h0) begin n_bad++;
      $display("FAIL reset_rdata got %h want 0", read_data); end
    n_vec++; if (mem_alu_result !== 32'h0) begin n_bad++;
      $display("FAIL reset_alu got %h want 0", mem_alu_result); end
    n_vec++; if (mem_write_reg !== 5'd0) begin n_bad++;
      $display("FAIL reset_reg got %0d want 0", mem_write_reg); end
    n_vec++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL reset_stall got %b want 0", stall); end
`ifdef MISALIGN_TRAP_EN
    n_vec++; if (misalign !== 1'b0) begin n_bad++;
      $display("FAIL reset_misalign got %b want 0", misalign); end
`endif
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int ns, nb;
    logic pc;
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5670, 32'h0, 5'd9);
    @(posedge clk); #1;
    n_vec++; if (mem_alu_result !== 32'h1234_5670) begin n_bad++;
      $display("FAIL pre_alu got %h want 12345670", mem_alu_result); end
    drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd7);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_bad++;
      $display("FAIL midwait_stall_on got %b want 1", stall); end
    @(posedge clk); #1;
    #1 rst = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL midwait_stall_drop got %b want 0", stall); end
    n_vec++; if ({mem_wb_ctl, read_data, mem_alu_result, mem_write_reg} !== 71'h0) begin
      n_bad++;
      $display("FAIL midwait_latch got ctl=%b rd=%h alu=%h reg=%0d want all 0",
               mem_wb_ctl, read_data, mem_alu_result, mem_write_reg); end
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3);
    model_access(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
    run_access(ns, nb, pc);
    n_vec++; if (read_data === 32'hDEAD_BEEF) begin n_bad++;
      $display("FAIL aborted_store got %h want not deadbeef", read_data); end
    n_vec++; if (ns != exp_stall) begin n_bad++;
      $display("FAIL after_reset_stall got %0d want %0d", ns, exp_stall); end
  endtask

  task automatic test_store_load();
    int ns, nb;
    logic pc;
    drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 5'd0);
    model_access(2'b00, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 5'd0);
    run_access(ns, nb, pc);
    n_vec++; if (ns != exp_stall) begin n_bad++;
      $display("FAIL store_stall got %0d want %0d", ns, exp_stall); end
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd5);
    model_access(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5);
    run_access(ns, nb, pc);
    n_vec++; if (ns != int'(WS)) begin n_bad++;
      $display("FAIL load_stall got %0d want %0d", ns, WS); end
    n_vec++; if (nb != 0) begin n_bad++;
      $display("FAIL load_bubble got %0d bad cycles want 0", nb); end
    n_vec++; if (read_data !== 32'h1234_5678) begin n_bad++;
      $display("FAIL load_data got %h want 12345678", read_data); end
    n_vec++; if (mem_write_reg !== 5'd5) begin n_bad++;
      $display("FAIL load_reg got %0d want 5", mem_write_reg); end
    n_vec++; if (mem_wb_ctl !== 2'b11) begin n_bad++;
      $display("FAIL load_ctl got %b want 11", mem_wb_ctl); end
  endtask

  task automatic test_branch();
    logic br, zr;
    for (int i = 0; i < 8; i++) begin
      br = (i < 4) ? i[0] : 1'($urandom);
      zr = (i < 4) ? i[1] : 1'($urandom);
      drive(2'($urandom), br, 1'b0, 1'b0, zr, $urandom, $urandom, 5'($urandom));
      #1;
      n_vec++; if (PCSrc !== (br & zr)) begin n_bad++;
        $display("FAIL branch_pcsrc got %b want %b", PCSrc, br & zr); end
      n_vec++; if (stall !== 1'b0) begin n_bad++;
        $display("FAIL branch_stall got %b want 0", stall); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    int ns, nb;
    logic pc;
    drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'hA5A5_A5A5, 5'd0);
    model_access(2'b00, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 5'd0);
    run_access(ns, nb, pc);
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd12);
    model_access(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 5'd12);
    run_access(ns, nb, pc);
    n_vec++; if (read_data !== 32'hA5A5_A5A5) begin n_bad++;
      $display("FAIL wrap_data got %h want a5a5a5a5", read_data); end
  endtask

  task automatic test_back_to_back();
    int ns, nb, kind;
    logic pc, br, zr, rd, wr;
    logic [31:0] r, addr, data;
    logic [1:0] ctl;
    logic [4:0] rg;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      rd   = (kind == 1 || kind == 3);
      wr   = (kind == 2 || kind == 3);
      br   = (kind == 0) ? 1'($urandom) : 1'b0;
      zr   = (kind == 0) ? 1'($urandom) : 1'b0;
      r    = $urandom;
      addr = {r[31:5], 3'($urandom_range(0, 7)), r[1:0]};
      data = $urandom;
      ctl  = 2'($urandom);
      rg   = 5'($urandom);
      drive(ctl, br, rd, wr, zr, addr, data, rg);
      model_access(ctl, rd, wr, addr, data, rg);
      run_access(ns, nb, pc);
      n_vec++; if (ns != exp_stall) begin n_bad++;
        $display("FAIL rnd%0d_stall got %0d want %0d", i, ns, exp_stall); end
      n_vec++; if (nb != 0) begin n_bad++;
        $display("FAIL rnd%0d_bubble got %0d bad cycles want 0", i, nb); end
      n_vec++; if (pc !== (br & zr)) begin n_bad++;
        $display("FAIL rnd%0d_pcsrc got %b want %b", i, pc, br & zr); end
      n_vec++; if (mem_wb_ctl !== exp_ctl) begin n_bad++;
        $display("FAIL rnd%0d_ctl got %b want %b", i, mem_wb_ctl, exp_ctl); end
      n_vec++; if (mem_alu_result !== exp_alu) begin n_bad++;
        $display("FAIL rnd%0d_alu got %h want %h", i, mem_alu_result, exp_alu); end
      n_vec++; if (mem_write_reg !== exp_reg) begin n_bad++;
        $display("FAIL rnd%0d_reg got %0d want %0d", i, mem_write_reg, exp_reg); end
      if (exp_rd_known) begin
        n_vec++; if (read_data !== exp_rd) begin n_bad++;
          $display("FAIL rnd%0d_rdata got %h want %h", i, read_data, exp_rd); end
      end
`ifdef MISALIGN_TRAP_EN
      n_vec++; if (misalign !== exp_mis) begin n_bad++;
        $display("FAIL rnd%0d_misalign got %b want %b", i, misalign, exp_mis); end
`endif
    end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    int ns, nb;
    logic pc;
    drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h41, 32'hFFFF_0000, 5'd4);
    model_access(2'b10, 1'b0, 1'b1, 32'h41, 32'hFFFF_0000, 5'd4);
    run_access(ns, nb, pc);
    n_vec++; if (ns != 0) begin n_bad++;
      $display("FAIL mis_stall got %0d want 0", ns); end
    n_vec++; if (misalign !== 1'b1) begin n_bad++;
      $display("FAIL mis_pulse got %b want 1", misalign); end
    n_vec++; if (mem_wb_ctl !== 2'b00) begin n_bad++;
      $display("FAIL mis_ctl got %b want 00", mem_wb_ctl); end
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    n_vec++; if (misalign !== 1'b0) begin n_bad++;
      $display("FAIL mis_pulse_end got %b want 0", misalign); end
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd6);
    model_access(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 5'd6);
    run_access(ns, nb, pc);
    n_vec++; if (read_data !== exp_rd) begin n_bad++;
      $display("FAIL mis_mem_kept got %h want %h", read_data, exp_rd); end
    drive(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'hCAFE_F00D, 5'd8);
    model_access(2'b11, 1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 5'd8);
    run_access(ns, nb, pc);
    n_vec++; if (read_data !== 32'h0) begin n_bad++;
      $display("FAIL both_rdata got %h want 0", read_data); end
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 5'd8);
    model_access(2'b11, 1'b1, 1'b0, 32'h44, 32'h0, 5'd8);
    run_access(ns, nb, pc);
    n_vec++; if (read_data !== 32'hCAFE_F00D) begin n_bad++;
      $display("FAIL both_stored got %h want cafef00d", read_data); end
  endtask
`endif

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mdl_known[i] = 0;
    test_reset();
    test_reset_mid_wait();
    test_store_load();
    test_branch();
    test_wrap();
    test_back_to_back();
`ifdef MISALIGN_TRAP_EN
    test_misalign();
`endif
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
